// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: FSM state encoding, reset pointer default
// and helpers that split a packed {hi, lo} instruction pointer.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ_HI,
    S_REQ_LO,
    S_WAIT,
    S_VALID
  } fetch_state_t;

  localparam logic [31:0] RESET_POINTER_DEFAULT = 32'h0000_0001;
  localparam int          DROP_W_DEFAULT        = 2;

  function automatic logic [15:0] ptr_hi(input logic [31:0] ptr);
    return ptr[31:16];
  endfunction

  function automatic logic [15:0] ptr_lo(input logic [31:0] ptr);
    return ptr[15:0];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the instruction-memory port, the decode handshake and the redirect
// inputs; master is the fetch unit, slave is memory plus decode/counter.
interface fetch_unit_if;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pointer;
  logic [31:0] next_pointer;
  logic        flush_valid;
  logic [31:0] flush_pointer;

  modport master (
    output mem_req, mem_addr, instr_valid, instruction, instr_pointer,
    input  mem_gnt, mem_rvalid, mem_rdata, instr_ready, next_pointer,
    input  flush_valid, flush_pointer
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instruction, instr_pointer,
    output mem_gnt, mem_rvalid, mem_rdata, instr_ready, next_pointer,
    output flush_valid, flush_pointer
  );

endinterface

// File: rtl/fetch_resp_tracker.sv
// Counts granted-but-unanswered reads, swallows responses that belong to a
// flushed fetch, and steers accepted responses into the hi or lo half.
module fetch_resp_tracker #(
  parameter int DROP_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic rvalid,
  input  logic flush,
  output logic cap_hi,
  output logic cap_lo
);

  localparam logic [DROP_W-1:0] MAX_OUT = DROP_W'(2);

  logic [DROP_W-1:0] outstanding_reg;
  logic [DROP_W-1:0] outstanding_next;
  logic [DROP_W-1:0] drop_reg;
  logic              word_sel_reg;
  logic              capture;

  assign capture = rvalid && (drop_reg == '0);
  assign cap_hi  = capture && !word_sel_reg;
  assign cap_lo  = capture && word_sel_reg;

  always_comb begin
    outstanding_next = outstanding_reg;
    if (issue && !rvalid && outstanding_reg != MAX_OUT) begin
      outstanding_next = outstanding_reg + 1'b1;
    end else if (!issue && rvalid && outstanding_reg != '0) begin
      outstanding_next = outstanding_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_reg <= '0;
      drop_reg        <= '0;
      word_sel_reg    <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (flush) begin
        // Everything still unanswered after this cycle belongs to the old stream.
        drop_reg     <= outstanding_next;
        word_sel_reg <= 1'b0;
      end else if (rvalid) begin
        if (drop_reg != '0) begin
          drop_reg <= drop_reg - 1'b1;
        end else begin
          word_sel_reg <= ~word_sel_reg;
        end
      end
    end
  end

  a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (rst)
    rvalid |-> (outstanding_reg != '0 || issue));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads hi and lo 16-bit words for the packed pointer,
// presents the 32-bit instruction to decode, and redirects on flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_POINTER = RESET_POINTER_DEFAULT,
  parameter int          DROP_W        = DROP_W_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  fetch_state_t state_reg;
  logic         mem_req_reg;
  logic [15:0]  mem_addr_reg;
  logic         instr_valid_reg;
  logic [31:0]  instruction_reg;
  logic [31:0]  instr_pointer_reg;
  logic         issue;
  logic         accept;
  logic         cap_hi;
  logic         cap_lo;

  // A request still waiting for grant is withdrawn in the flush cycle.
  assign bus.mem_req       = mem_req_reg && !bus.flush_valid;
  assign bus.mem_addr      = mem_addr_reg;
  assign bus.instr_valid   = instr_valid_reg;
  assign bus.instruction   = instruction_reg;
  assign bus.instr_pointer = instr_pointer_reg;

  assign issue  = bus.mem_req && bus.mem_gnt;
  assign accept = instr_valid_reg && bus.instr_ready;

  fetch_resp_tracker #(.DROP_W(DROP_W)) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .issue  (issue),
    .rvalid (bus.mem_rvalid),
    .flush  (bus.flush_valid),
    .cap_hi (cap_hi),
    .cap_lo (cap_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_REQ_HI;
      mem_req_reg       <= 1'b0;
      mem_addr_reg      <= 16'h0000;
      instr_valid_reg   <= 1'b0;
      instruction_reg   <= 32'h0000_0000;
      instr_pointer_reg <= RESET_POINTER;
    end else if (bus.flush_valid) begin
      state_reg         <= S_REQ_HI;
      mem_req_reg       <= 1'b1;
      mem_addr_reg      <= ptr_hi(bus.flush_pointer);
      instr_valid_reg   <= 1'b0;
      instr_pointer_reg <= bus.flush_pointer;
    end else begin
      if (cap_hi) instruction_reg[31:16] <= bus.mem_rdata;
      if (cap_lo) instruction_reg[15:0]  <= bus.mem_rdata;
      case (state_reg)
        S_REQ_HI: begin
          if (!mem_req_reg) begin
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= ptr_hi(instr_pointer_reg);
          end else if (bus.mem_gnt) begin
            state_reg    <= S_REQ_LO;
            mem_addr_reg <= ptr_lo(instr_pointer_reg);
          end
        end
        S_REQ_LO: begin
          if (bus.mem_gnt) begin
            mem_req_reg <= 1'b0;
            // A same-cycle answer to the lo request completes the instruction now.
            if (cap_lo) begin
              state_reg       <= S_VALID;
              instr_valid_reg <= 1'b1;
            end else begin
              state_reg <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cap_lo) begin
            state_reg       <= S_VALID;
            instr_valid_reg <= 1'b1;
          end
        end
        S_VALID: begin
          if (accept) begin
            state_reg         <= S_REQ_HI;
            instr_valid_reg   <= 1'b0;
            instr_pointer_reg <= bus.next_pointer;
            mem_req_reg       <= 1'b1;
            mem_addr_reg      <= ptr_hi(bus.next_pointer);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with programmable latency,
// address/instruction scoreboards, table-driven fetches and flush/reset sequences.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_POINTER (32'h0000_0001),
    .DROP_W        (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] ptr;
  } instr_exp_t;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] ptr;
    int          lat;
    int          stall;
    int          gnt_hold;
    logic [31:0] exp_instr;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  int          mem_lat  = 1;
  int          cyc      = 0;
  logic [15:0] exp_addr_q[$];
  instr_exp_t  exp_instr_q[$];
  pend_t       pend_q[$];
  vec_t        vecs[4];

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    case (addr)
      16'h0000: return 16'h4800;
      16'h0001: return 16'h0123;
      default:  return addr ^ 16'hA5C3;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check32("valid_timeout", {31'd0, bus.instr_valid}, 32'd1);
  endtask

  // Memory model and scoreboards: sample just before each edge, respond just after.
  initial begin : env
    logic        hs;
    logic        acc;
    logic        r;
    logic [15:0] a;
    instr_exp_t  e;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      #4;
      r   = rst;
      hs  = bus.mem_req && bus.mem_gnt;
      a   = bus.mem_addr;
      acc = bus.instr_valid && bus.instr_ready && !bus.flush_valid;
      if (!r && hs) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_addr_unexpected: got %h, required no request", a);
        end else begin
          check32("mem_addr_seq", {16'h0, a}, {16'h0, exp_addr_q.pop_front()});
        end
      end
      if (!r && acc) begin
        if (exp_instr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL accept_unexpected: got %h, required no instruction", bus.instruction);
        end else begin
          e = exp_instr_q.pop_front();
          check32("sb_instruction", bus.instruction, e.instr);
          check32("sb_instr_pointer", bus.instr_pointer, e.ptr);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
        pend_q.delete();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'h0000;
      end else begin
        if (hs) pend_q.push_back('{a, cyc + mem_lat - 1});
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_word(pend_q[0].addr);
          void'(pend_q.pop_front());
        end else begin
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = 16'h0000;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          n;
    logic [31:0] nxt;
    vecs[0] = '{32'h0000_0001, 1, 0, 0, 32'h4800_0123};
    vecs[1] = '{32'h0123_0124, 1, 5, 0, 32'hA4E0_A4E7};
    vecs[2] = '{32'h1234_5678, 2, 0, 3, 32'hB7F7_F3BB};
    vecs[3] = '{32'hFFFF_0000, 3, 1, 0, 32'h5A3C_4800};

    bus.mem_gnt       = 1'b1;
    bus.instr_ready   = 1'b0;
    bus.next_pointer  = 32'h0;
    bus.flush_valid   = 1'b0;
    bus.flush_pointer = 32'h0;
    repeat (3) @(negedge clk);
    check32("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check32("rst_mem_addr", {16'h0, bus.mem_addr}, 32'd0);
    check32("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check32("rst_instruction", bus.instruction, 32'd0);
    check32("rst_instr_pointer", bus.instr_pointer, 32'h0000_0001);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mem_lat = vecs[i].lat;
      exp_addr_q.push_back(vecs[i].ptr[31:16]);
      exp_addr_q.push_back(vecs[i].ptr[15:0]);
      exp_instr_q.push_back('{vecs[i].exp_instr, vecs[i].ptr});
      if (vecs[i].gnt_hold > 0) begin
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        for (int k = 0; k < vecs[i].gnt_hold; k++) begin
          check32("gnt_hold_req", {31'd0, bus.mem_req}, 32'd1);
          check32("gnt_hold_addr", {16'h0, bus.mem_addr}, {16'h0, vecs[i].ptr[15:0]});
          @(negedge clk);
        end
        bus.mem_gnt = 1'b1;
      end
      wait_valid(n);
      if (i == 0) check32("first_fetch_latency", n, 32'd4);
      for (int s = 0; s < vecs[i].stall; s++) begin
        check32("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
        check32("stall_instruction", bus.instruction, vecs[i].exp_instr);
        check32("stall_pointer", bus.instr_pointer, vecs[i].ptr);
        check32("stall_no_req", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
      end
      nxt = (i < 3) ? vecs[i+1].ptr : 32'h0000_0001;
      bus.next_pointer = nxt;
      bus.instr_ready  = 1'b1;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      check32("accept_valid_low", {31'd0, bus.instr_valid}, 32'd0);
      check32("accept_next_req", {31'd0, bus.mem_req}, 32'd1);
      check32("accept_next_addr", {16'h0, bus.mem_addr}, {16'h0, nxt[31:16]});
    end

    // Flush with both requests of the current fetch still in flight.
    mem_lat = 3;
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0001);
    @(negedge clk);
    @(negedge clk);
    check32("wait_no_req", {31'd0, bus.mem_req}, 32'd0);
    bus.flush_valid   = 1'b1;
    bus.flush_pointer = 32'h0040_0041;
    exp_addr_q.push_back(16'h0040);
    exp_addr_q.push_back(16'h0041);
    exp_instr_q.push_back('{32'hA583_A582, 32'h0040_0041});
    @(negedge clk);
    bus.flush_valid = 1'b0;
    check32("flush_valid_low", {31'd0, bus.instr_valid}, 32'd0);
    check32("flush_redirect_addr", {16'h0, bus.mem_addr}, 32'h0000_0040);
    wait_valid(n);
    check32("flush_instruction", bus.instruction, 32'hA583_A582);
    check32("flush_pointer", bus.instr_pointer, 32'h0040_0041);
    bus.next_pointer = 32'h1234_5678;
    bus.instr_ready  = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;

    // Flush while a request is pending: it must be withdrawn, not issued.
    mem_lat           = 2;
    bus.flush_valid   = 1'b1;
    bus.flush_pointer = 32'hFFFF_0000;
    #1;
    check32("flush_withdraw_req", {31'd0, bus.mem_req}, 32'd0);
    exp_addr_q.push_back(16'hFFFF);
    exp_addr_q.push_back(16'h0000);
    exp_instr_q.push_back('{32'h5A3C_4800, 32'hFFFF_0000});
    @(negedge clk);
    bus.flush_valid = 1'b0;
    wait_valid(n);
    check32("wrap_instruction", bus.instruction, 32'h5A3C_4800);
    check32("wrap_pointer", bus.instr_pointer, 32'hFFFF_0000);

    // Reset in S_WAIT with both responses outstanding.
    mem_lat = 3;
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0001);
    bus.next_pointer = 32'h0000_0001;
    bus.instr_ready  = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check32("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check32("midrst_mem_addr", {16'h0, bus.mem_addr}, 32'd0);
    check32("midrst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check32("midrst_instruction", bus.instruction, 32'd0);
    check32("midrst_instr_pointer", bus.instr_pointer, 32'h0000_0001);

    mem_lat = 1;
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0001);
    exp_instr_q.push_back('{32'h4800_0123, 32'h0000_0001});
    rst = 1'b0;
    wait_valid(n);
    check32("post_rst_latency", n, 32'd4);
    bus.next_pointer = 32'h0040_0041;
    bus.instr_ready  = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.mem_gnt     = 1'b0;
    repeat (3) @(negedge clk);
    check32("addr_q_drained", exp_addr_q.size(), 32'd0);
    check32("instr_q_drained", exp_instr_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. It produces the 32-bit instruction and packed instruction pointer that the counter block consumes. It takes back the counter's _next_pointer as the address of the next fetch.
- It reads two 16-bit words from instruction memory per instruction:
  - high word at instr_pointer[31:16]
  - low word at instr_pointer[15:0]
- It presents the assembled instruction to decode through a valid/ready handshake.
- It supports a flush/redirect for exceptions, and discards responses still in flight.

Parameters:
- RESET_POINTER, 32'h0000_0001, packed {ip, ip+1} loaded at reset.
- DROP_W, 2, width of the in-flight/drop counter (max 2 outstanding requests).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- mem_req  output  1  read request valid.
- mem_addr  output  16  word address of the request.
- mem_gnt  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  read data valid; responses return in request order, latency >= 1.
- mem_rdata  input  16  read data.
- instr_valid  output  1  instruction and instr_pointer are valid.
- instr_ready  input  1  decode/counter accepts the instruction.
- instruction  output  32  {word@hi, word@lo}.
- instr_pointer  output  32  packed pointer the instruction was fetched from.
- next_pointer  input  32  counter's _next_pointer; sampled on accept.
- flush_valid  input  1  redirect request.
- flush_pointer  input  32  redirect target, same packing as instr_pointer.

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values:
  - mem_req=0, mem_addr=0
  - instr_valid=0, instruction=0
  - instr_pointer=RESET_POINTER
  - drop counter=0, state=S_REQ_HI
- Memory shares rst, so no response arrives for a request issued before reset.
- FSM states: S_REQ_HI, S_REQ_LO, S_WAIT, S_VALID.
- S_REQ_HI:
  - mem_req=1, mem_addr=instr_pointer[31:16].
  - On mem_gnt, go to S_REQ_LO.
- S_REQ_LO:
  - mem_req=1, mem_addr=instr_pointer[15:0].
  - On mem_gnt, go to S_WAIT.
- S_WAIT:
  - mem_req=0; wait until both responses are captured.
  - Go to S_VALID in the cycle after the second rvalid.
- Response capture:
  - First accepted response fills instruction[31:16]; second fills [15:0].
  - A response may arrive while in S_REQ_LO and is captured there.
  - A response may arrive in the same cycle as the gnt it answers; it is captured.
- S_VALID:
  - instr_valid=1; instruction and instr_pointer are held stable while instr_ready=0.
  - On instr_valid && instr_ready: instr_pointer<=next_pointer, instr_valid<=0 next cycle, go to S_REQ_HI.
  - Accept-to-next-mem_req latency is 1 cycle.
  - Minimum fetch latency with 1-cycle memory and mem_gnt tied 1: 4 cycles from mem_req to instr_valid.
- Address wrap: both halves are used verbatim. {16'hFFFF, 16'h0000} fetches 0xFFFF then 0x0000; the unit does no arithmetic on pointers.
- Flush (priority over accept and over every FSM transition):
  - instr_pointer<=flush_pointer, instr_valid<=0, state<=S_REQ_HI.
  - drop counter <= granted-but-unanswered requests, computed including any gnt/rvalid in the flush cycle.
  - While drop>0, each mem_rvalid decrements drop and its data is discarded; only then does capture resume.
  - New requests may be issued while drop>0; in-order return guarantees correctness.
  - mem_req is 0 during the flush cycle. A pending ungranted request is withdrawn; only a mem_req=1 && mem_gnt pair counts as issued.
- Flush with instr_valid && instr_ready in the same cycle: flush wins and next_pointer is ignored.
- Reset mid-operation behaves exactly like the reset-value state; the drop counter clears.
- In-flight count never exceeds 2. The drop counter saturates at 2, and an assertion fires if rvalid arrives with nothing outstanding.

Decomposition:
- Shared package (types): fetch_state_t enum (S_REQ_HI, S_REQ_LO, S_WAIT, S_VALID) and localparam RESET_POINTER default.
- Packed-pointer helpers ptr_hi/ptr_lo functions also go in the package, for reuse by counter and decode.
- One natural sub-module: fetch_resp_tracker. It owns the outstanding/drop counters and the word-select (hi/lo) capture enable.

Test Plan:
- Reset, mem latency 1, gnt=1, mem[0]=16'h4800, mem[1]=16'h0123, instr_ready=1 -> mem_addr 0 then 1; instr_valid on cycle 4 with instruction=32'h4800_0123, instr_pointer=32'h0000_0001.
- Accept with next_pointer=32'h0123_0124 (counter JMP to 0x0123) -> next mem_addr sequence 0x0123, 0x0124 one cycle after accept; new instr_pointer=32'h0123_0124.
- Backpressure: instr_ready=0 for 5 cycles in S_VALID -> instruction/instr_pointer stable, mem_req=0 throughout; accept on cycle 6 proceeds normally.
- mem_gnt low 3 cycles during S_REQ_LO -> mem_addr held at lo address and mem_req held 1; instruction assembles correctly after grant.
- Flush with 2 requests in flight (latency 3) to flush_pointer=32'h0040_0041 -> two stale responses discarded; instruction = {mem[0x40], mem[0x41]}, instr_pointer=32'h0040_0041.
- Wrap: next_pointer=32'hFFFF_0000 -> mem_addr 0xFFFF then 0x0000; instruction={mem[0xFFFF], mem[0x0000]}. Separately, rst asserted in S_WAIT -> all outputs return to reset values next cycle.
